// File: rtl/ram_banked_clr_pkg.sv
// Shared types and default sizing for the banked, self-clearing data RAM.
package ram_banked_clr_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  localparam int unsigned DEF_WIDTH       = 16;
  localparam int unsigned DEF_BANK_ADDR_W = 6;
  localparam int unsigned DEF_BANK_SEL_W  = 3;
  localparam int unsigned DEF_ADDR_W      = DEF_BANK_SEL_W + DEF_BANK_ADDR_W;

endpackage

// File: rtl/ram_banked_clr_if.sv
// CPU-side access bus of the banked RAM: write data, address, strobes, read data and busy.
interface ram_banked_clr_if
  import ram_banked_clr_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  logic [WIDTH-1:0]  in;
  logic [ADDR_W-1:0] addr;
  logic              load;
  logic              clear;
  logic [WIDTH-1:0]  out;
  logic              busy;

  modport master (output in, addr, load, clear, input out, busy);
  modport slave  (input in, addr, load, clear, output out, busy);

endinterface

// File: rtl/ram_banked_clr_bank.sv
// One RAM bank: synchronous write, combinational read.
module ram_bank
  import ram_banked_clr_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned BANK_ADDR_W = DEF_BANK_ADDR_W
) (
  input  logic                   clk,
  input  logic                   we_i,
  input  logic [BANK_ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic [BANK_ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]       rdata_o
);

  logic [WIDTH-1:0] mem_q [2**BANK_ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ram_banked_clr.sv
// Banked data RAM with registered read and a hardware clear sweep after reset or on request.
module ram_banked_clr
  import ram_banked_clr_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned BANK_ADDR_W = DEF_BANK_ADDR_W,
  parameter int unsigned BANK_SEL_W  = DEF_BANK_SEL_W
) (
  input  logic             clk,
  input  logic             reset,
  ram_banked_clr_if.slave  bus
);

  localparam int unsigned ADDR_W = BANK_SEL_W + BANK_ADDR_W;
  localparam int unsigned NBANKS = 2**BANK_SEL_W;
  localparam logic [BANK_ADDR_W-1:0] SWEEP_LAST = '1;

  state_e                 state_q, state_d;
  logic [BANK_ADDR_W-1:0] sweep_q, sweep_d;
  logic [WIDTH-1:0]       out_q, out_d;

  logic [BANK_SEL_W-1:0]  bank_sel;
  logic [BANK_ADDR_W-1:0] local_addr;
  logic [NBANKS-1:0]      bank_we;
  logic [BANK_ADDR_W-1:0] bank_waddr;
  logic [WIDTH-1:0]       bank_wdata;
  logic [WIDTH-1:0]       bank_rdata [NBANKS];

  assign bank_sel   = bus.addr[ADDR_W-1:BANK_ADDR_W];
  assign local_addr = bus.addr[BANK_ADDR_W-1:0];

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    ram_bank #(
      .WIDTH       (WIDTH),
      .BANK_ADDR_W (BANK_ADDR_W)
    ) u_bank (
      .clk     (clk),
      .we_i    (bank_we[b]),
      .waddr_i (bank_waddr),
      .wdata_i (bank_wdata),
      .raddr_i (local_addr),
      .rdata_o (bank_rdata[b])
    );
  end

  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    out_d      = '0;
    bank_we    = '0;
    bank_waddr = local_addr;
    bank_wdata = bus.in;
    case (state_q)
      ST_CLEAR: begin
        bank_we    = '1;
        bank_waddr = sweep_q;
        bank_wdata = '0;
        sweep_d    = sweep_q + 1'b1;
        if (sweep_q == SWEEP_LAST) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        bank_we[bank_sel] = bus.load;
        // Read and write share one address, so write-first means forwarding the write data.
        out_d = bus.load ? bus.in : bank_rdata[bank_sel];
        if (bus.clear) begin
          state_d = ST_CLEAR;
          sweep_d = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      sweep_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      out_q   <= out_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = (state_q == ST_CLEAR);

endmodule
